// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the GMII MAC transmit and receive paths.
//   - preamble/SFD byte values and preamble length
//   - CRC-32 polynomial (reflected), initial value and good-frame residue
//   - transmit FSM state type
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  ETH_SFD           = 8'hD5;
   localparam int unsigned ETH_PREAMBLE_LEN  = 7;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      PAYLOAD,
      PAD,
      FCS,
      DRAIN,
      IFG
   } tx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the Ethernet CRC-32 (reflected, LSB first).
// Ports:
//   crc_in  [31:0]  running CRC register
//   data    [7:0]   byte to fold in
//   crc_out [31:0]  updated CRC register (no final inversion)
module eth_crc32_byte
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {24'h0, data};
      for (int unsigned i = 0; i < 8; i++) begin
         crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY) : (crc_out >> 1);
      end
   end

endmodule

// File: rtl/gmii_mac_tx.sv
// Byte-wide Ethernet MAC transmitter: AXI-Stream frame in, GMII out.
// Adds preamble/SFD, pads short frames, appends FCS, enforces the IFG.
// Ports:
//   clk, rst_n                 GMII TX clock, async active-low reset
//   s_axis_tdata/tvalid/tready/tlast/tuser   payload stream (tuser+tlast = abort)
//   gmii_txd/gmii_tx_en/gmii_tx_er           registered GMII outputs
//   start_packet               pulse with the first preamble byte on txd
//   error_underflow            pulse with the error cycle on txd
module gmii_mac_tx
   import eth_pkg::*;
#(
   parameter bit          ENABLE_PADDING   = 1'b1,
   parameter int unsigned MIN_FRAME_LENGTH = 64,
   parameter int unsigned IFG_CYCLES       = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       start_packet,
   output logic       error_underflow
);

   localparam logic [15:0] MIN_PAYLOAD = 16'(MIN_FRAME_LENGTH - 4);
   localparam logic [15:0] IFG_LAST    = 16'(IFG_CYCLES - 1);
   localparam logic [15:0] PRE_LAST    = 16'(ETH_PREAMBLE_LEN - 1);

   tx_state_t   state, state_nxt;
   logic [15:0] byte_cnt, byte_cnt_nxt, cnt_inc;
   logic [15:0] aux_cnt, aux_cnt_nxt;
   logic [31:0] crc, crc_nxt, crc_upd, fcs_word;
   logic [7:0]  crc_data;
   logic [7:0]  txd_nxt;
   logic        tx_en_nxt, tx_er_nxt, start_nxt, uflow_nxt;

   // Combinational outputs below compute what goes on the wire next cycle;
   // the IDLE cycle already launches the first preamble byte, so PREAMBLE
   // launches the remaining six 0x55 plus the SFD and PAYLOAD starts while
   // the SFD is on txd.
   assign s_axis_tready = (state == PAYLOAD) || (state == DRAIN);
   assign crc_data      = (state == PAYLOAD) ? s_axis_tdata : 8'h00;
   assign cnt_inc       = (byte_cnt == '1) ? byte_cnt : byte_cnt + 16'd1;
   assign fcs_word      = ~crc;

   eth_crc32_byte u_crc (
      .crc_in  (crc),
      .data    (crc_data),
      .crc_out (crc_upd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         byte_cnt        <= '0;
         aux_cnt         <= '0;
         crc             <= CRC32_INIT;
         gmii_txd        <= '0;
         gmii_tx_en      <= 1'b0;
         gmii_tx_er      <= 1'b0;
         start_packet    <= 1'b0;
         error_underflow <= 1'b0;
      end else begin
         state           <= state_nxt;
         byte_cnt        <= byte_cnt_nxt;
         aux_cnt         <= aux_cnt_nxt;
         crc             <= crc_nxt;
         gmii_txd        <= txd_nxt;
         gmii_tx_en      <= tx_en_nxt;
         gmii_tx_er      <= tx_er_nxt;
         start_packet    <= start_nxt;
         error_underflow <= uflow_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      aux_cnt_nxt  = aux_cnt;
      crc_nxt      = crc;
      case (state)
         IDLE: begin
            byte_cnt_nxt = '0;
            aux_cnt_nxt  = '0;
            crc_nxt      = CRC32_INIT;
            if (s_axis_tvalid) state_nxt = PREAMBLE;
         end
         PREAMBLE: begin
            if (aux_cnt == PRE_LAST) begin
               state_nxt   = PAYLOAD;
               aux_cnt_nxt = '0;
            end else begin
               aux_cnt_nxt = aux_cnt + 16'd1;
            end
         end
         PAYLOAD: begin
            if (s_axis_tvalid) begin
               crc_nxt      = crc_upd;
               byte_cnt_nxt = cnt_inc;
               if (s_axis_tlast) begin
                  if (s_axis_tuser)
                     state_nxt = IFG;
                  else if (ENABLE_PADDING && (cnt_inc < MIN_PAYLOAD))
                     state_nxt = PAD;
                  else
                     state_nxt = FCS;
               end
            end else begin
               // tlast cannot have been accepted yet here, so always drain
               state_nxt = DRAIN;
            end
         end
         PAD: begin
            crc_nxt      = crc_upd;
            byte_cnt_nxt = cnt_inc;
            if (cnt_inc >= MIN_PAYLOAD) state_nxt = FCS;
         end
         FCS: begin
            if (aux_cnt[1:0] == 2'd3) begin
               state_nxt   = IFG;
               aux_cnt_nxt = '0;
            end else begin
               aux_cnt_nxt = aux_cnt + 16'd1;
            end
         end
         DRAIN: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_nxt   = IFG;
               aux_cnt_nxt = '0;
            end
         end
         IFG: begin
            if (aux_cnt == IFG_LAST) begin
               state_nxt   = IDLE;
               aux_cnt_nxt = '0;
            end else begin
               aux_cnt_nxt = aux_cnt + 16'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      txd_nxt   = 8'h00;
      tx_en_nxt = 1'b0;
      tx_er_nxt = 1'b0;
      start_nxt = 1'b0;
      uflow_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (s_axis_tvalid) begin
               txd_nxt   = ETH_PREAMBLE_BYTE;
               tx_en_nxt = 1'b1;
               start_nxt = 1'b1;
            end
         end
         PREAMBLE: begin
            tx_en_nxt = 1'b1;
            txd_nxt   = (aux_cnt == PRE_LAST) ? ETH_SFD : ETH_PREAMBLE_BYTE;
         end
         PAYLOAD: begin
            tx_en_nxt = 1'b1;
            if (s_axis_tvalid) begin
               txd_nxt   = s_axis_tdata;
               tx_er_nxt = s_axis_tlast & s_axis_tuser;
            end else begin
               tx_er_nxt = 1'b1;
               uflow_nxt = 1'b1;
            end
         end
         PAD: begin
            tx_en_nxt = 1'b1;
         end
         FCS: begin
            tx_en_nxt = 1'b1;
            case (aux_cnt[1:0])
               2'd0:    txd_nxt = fcs_word[7:0];
               2'd1:    txd_nxt = fcs_word[15:8];
               2'd2:    txd_nxt = fcs_word[23:16];
               default: txd_nxt = fcs_word[31:24];
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gmii_mac_tx.sv
module tb_gmii_mac_tx;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;        // 0: padding instance, 1: no-padding instance
   logic [7:0] tdata = 8'h00;
   logic       tvalid = 1'b0;
   logic       tlast = 1'b0;
   logic       tuser = 1'b0;

   logic       tready_a, tready_b, en_a, en_b, er_a, er_b, sp_a, sp_b, uf_a, uf_b;
   logic [7:0] txd_a, txd_b;
   logic       tvalid_a, tvalid_b, tready, en, er, sp, uf;
   logic [7:0] txd;

   int n_tests = 0;
   int n_fail  = 0;

   always #4 clk = ~clk;

   assign tvalid_a = tvalid & ~sel;
   assign tvalid_b = tvalid & sel;
   assign tready   = sel ? tready_b : tready_a;
   assign txd      = sel ? txd_b : txd_a;
   assign en       = sel ? en_b : en_a;
   assign er       = sel ? er_b : er_a;
   assign sp       = sel ? sp_b : sp_a;
   assign uf       = sel ? uf_b : uf_a;

   gmii_mac_tx #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64), .IFG_CYCLES(12)) dut_pad (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_a), .s_axis_tready(tready_a),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .gmii_txd(txd_a), .gmii_tx_en(en_a), .gmii_tx_er(er_a),
      .start_packet(sp_a), .error_underflow(uf_a)
   );

   gmii_mac_tx #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64), .IFG_CYCLES(12)) dut_nopad (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid_b), .s_axis_tready(tready_b),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .gmii_txd(txd_b), .gmii_tx_en(en_b), .gmii_tx_er(er_b),
      .start_packet(sp_b), .error_underflow(uf_b)
   );

   // ---------------- wire log, sampled on the falling edge ----------------
   bit         cap = 1'b0;
   logic [7:0] lg_d[$];
   bit         lg_en[$], lg_er[$], lg_sp[$], lg_uf[$];
   int         b_st[$], b_ln[$];

   always @(negedge clk) begin
      if (cap) begin
         lg_d.push_back(txd);
         lg_en.push_back(en);
         lg_er.push_back(er);
         lg_sp.push_back(sp);
         lg_uf.push_back(uf);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] crc_of(input bq_t d);
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         c = c ^ {24'h0, d[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic bq_t preamble();
      bq_t q;
      for (int i = 0; i < 7; i++) q.push_back(8'h55);
      q.push_back(8'hD5);
      return q;
   endfunction

   // Expected on-wire frame for a normal (non-aborted) transmission.
   function automatic bq_t build_frame(input bq_t pl, input bit pad);
      bq_t fr = preamble();
      bq_t body = pl;
      logic [31:0] fcs;
      if (pad) while (body.size() < 60) body.push_back(8'h00);
      fcs = ~crc_of(body);
      foreach (body[i]) fr.push_back(body[i]);
      for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
      return fr;
   endfunction

   function automatic bq_t rand_payload(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // ---------------- helpers ----------------
   task automatic clear_log();
      lg_d.delete(); lg_en.delete(); lg_er.delete(); lg_sp.delete(); lg_uf.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void find_bursts();
      int i = 0;
      b_st.delete();
      b_ln.delete();
      while (i < lg_en.size()) begin
         if (lg_en[i]) begin
            int s;
            s = i;
            while (i < lg_en.size() && lg_en[i]) i++;
            b_st.push_back(s);
            b_ln.push_back(i - s);
         end else begin
            i++;
         end
      end
   endfunction

   function automatic int count_q(input bit q[$]);
      int c = 0;
      foreach (q[i]) if (q[i]) c++;
      return c;
   endfunction

   // Present a payload on the stream; gap_at>=0 drops tvalid for one cycle
   // once that many bytes have been accepted.
   task automatic send_frame(input bq_t pl, input bit user_last, input int gap_at);
      int  i = 0;
      int  budget = 5000;
      bit  gapped = 1'b0;
      bit  hs;
      while (i < pl.size()) begin
         if (!gapped && i == gap_at) begin
            tvalid = 1'b0;
            gapped = 1'b1;
            @(posedge clk);
            #1;
         end else begin
            tvalid = 1'b1;
            tdata  = pl[i];
            tlast  = (i == pl.size() - 1);
            tuser  = user_last && (i == pl.size() - 1);
            @(negedge clk);
            hs = tready;
            @(posedge clk);
            #1;
            if (hs) i++;
         end
         budget--;
         if (budget == 0) begin
            check("send_timeout", 64'(i), 64'(pl.size()));
            break;
         end
      end
   endtask

   task automatic bus_idle();
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
   endtask

   task automatic run_one(input bq_t pl, input logic s, input bit user_last, input int gap_at);
      sel = s;
      clear_log();
      cap = 1'b1;
      send_frame(pl, user_last, gap_at);
      bus_idle();
      wait_cycles(100);
      cap = 1'b0;
      find_bursts();
   endtask

   task automatic check_frame(input string tag, input int b, input bq_t exp,
                              input int exp_er, input bit residue);
      int  st = b_st[b];
      int  ln = b_ln[b];
      int  mism = 0;
      int  ers = 0;
      bq_t body;
      check({tag, "_len"}, 64'(ln), 64'(exp.size()));
      for (int k = 0; k < ln && k < exp.size(); k++) if (lg_d[st+k] !== exp[k]) mism++;
      check({tag, "_data_mismatches"}, 64'(mism), 64'd0);
      for (int k = 0; k < ln; k++) if (lg_er[st+k]) ers++;
      check({tag, "_er_count"}, 64'(ers), 64'(exp_er));
      check({tag, "_start_pulse"}, 64'(lg_sp[st]), 64'd1);
      if (residue) begin
         for (int k = 8; k < ln; k++) body.push_back(lg_d[st+k]);
         check({tag, "_residue"}, 64'(crc_of(body)), 64'h00000000DEBB20E3);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bq_t pl, pl2, exp;
      int  st;

      // reset values, with tvalid asserted to show it is ignored
      tvalid = 1'b1;
      #21;
      check("reset_out_pad",   {txd_a, en_a, er_a, sp_a, uf_a, tready_a}, 64'd0);
      check("reset_out_nopad", {txd_b, en_b, er_b, sp_b, uf_b, tready_b}, 64'd0);
      bus_idle();
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(3);

      // minimum padded frame
      pl = {8'hAA};
      run_one(pl, 1'b0, 1'b0, -1);
      check("min_bursts", 64'(b_st.size()), 64'd1);
      if (b_st.size() >= 1) begin
         check("min_txen_cycles", 64'(b_ln[0]), 64'd72);
         check_frame("min", 0, build_frame(pl, 1'b1), 0, 1'b1);
      end
      check("min_uf_pulses", 64'(count_q(lg_uf)), 64'd0);

      // CRC check value without padding
      pl.delete();
      for (int k = 1; k <= 9; k++) pl.push_back(8'(8'h30 + k));
      run_one(pl, 1'b1, 1'b0, -1);
      check("crc9_bursts", 64'(b_st.size()), 64'd1);
      if (b_st.size() >= 1) begin
         st = b_st[0] + b_ln[0] - 4;
         check("crc9_fcs0", 64'(lg_d[st]),   64'h26);
         check("crc9_fcs1", 64'(lg_d[st+1]), 64'h39);
         check("crc9_fcs2", 64'(lg_d[st+2]), 64'hF4);
         check("crc9_fcs3", 64'(lg_d[st+3]), 64'hCB);
         check_frame("crc9", 0, build_frame(pl, 1'b0), 0, 1'b1);
      end

      // back-to-back frames with tvalid held high
      sel = 1'b0;
      pl  = rand_payload(100);
      pl2 = rand_payload(100);
      clear_log();
      cap = 1'b1;
      send_frame(pl, 1'b0, -1);
      send_frame(pl2, 1'b0, -1);
      bus_idle();
      wait_cycles(60);
      cap = 1'b0;
      find_bursts();
      check("b2b_bursts", 64'(b_st.size()), 64'd2);
      check("b2b_start_pulses", 64'(count_q(lg_sp)), 64'd2);
      if (b_st.size() >= 2) begin
         check_frame("b2b_f0", 0, build_frame(pl, 1'b1), 0, 1'b1);
         check_frame("b2b_f1", 1, build_frame(pl2, 1'b1), 0, 1'b1);
         check("b2b_ifg", 64'(b_st[1] - (b_st[0] + b_ln[0])), 64'd12);
      end

      // underflow after 20 bytes of a 64-byte payload
      pl = rand_payload(64);
      run_one(pl, 1'b0, 1'b0, 20);
      check("uf_bursts", 64'(b_st.size()), 64'd1);
      check("uf_pulses", 64'(count_q(lg_uf)), 64'd1);
      if (b_st.size() >= 1) begin
         exp = preamble();
         for (int k = 0; k < 20; k++) exp.push_back(pl[k]);
         exp.push_back(8'h00);
         check_frame("uf", 0, exp, 1, 1'b0);
         check("uf_er_pos", 64'(lg_er[b_st[0] + 28]), 64'd1);
         check("uf_pulse_pos", 64'(lg_uf[b_st[0] + 28]), 64'd1);
      end
      pl = rand_payload(30);
      run_one(pl, 1'b0, 1'b0, -1);
      check("uf_recover_bursts", 64'(b_st.size()), 64'd1);
      if (b_st.size() >= 1) check_frame("uf_recover", 0, build_frame(pl, 1'b1), 0, 1'b1);

      // abort on byte 70
      pl = rand_payload(70);
      run_one(pl, 1'b0, 1'b1, -1);
      check("abort_bursts", 64'(b_st.size()), 64'd1);
      if (b_st.size() >= 1) begin
         exp = preamble();
         foreach (pl[k]) exp.push_back(pl[k]);
         check_frame("abort", 0, exp, 1, 1'b0);
         check("abort_er_last", 64'(lg_er[b_st[0] + 77]), 64'd1);
      end

      // randomized frames on either instance
      for (int r = 0; r < 8; r++) begin
         logic s;
         s  = 1'($urandom_range(0, 1));
         pl = rand_payload($urandom_range(1, 130));
         wait_cycles($urandom_range(0, 5));
         run_one(pl, s, 1'b0, -1);
         check($sformatf("rnd%0d_bursts", r), 64'(b_st.size()), 64'd1);
         if (b_st.size() >= 1)
            check_frame($sformatf("rnd%0d", r), 0, build_frame(pl, !s), 0, 1'b1);
      end

      // reset mid-payload
      sel    = 1'b0;
      tvalid = 1'b1;
      tlast  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tdata = 8'($urandom);
         @(posedge clk);
         #1;
      end
      check("rstmid_en_before", 64'(en_a), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_out", {txd_a, en_a, er_a, sp_a, uf_a, tready_a}, 64'd0);
      bus_idle();
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(3);
      pl = rand_payload(50);
      run_one(pl, 1'b0, 1'b0, -1);
      check("rstmid_next_bursts", 64'(b_st.size()), 64'd1);
      if (b_st.size() >= 1) check_frame("rstmid_next", 0, build_frame(pl, 1'b1), 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/gmii_mac_tx.md
Name: gmii_mac_tx

Overview:
- Byte-wide Ethernet MAC transmitter. Converts an AXI-Stream frame into GMII transmit signalling towards a PHY.
- Inserts preamble and SFD, pads short frames, appends the FCS and enforces the inter-frame gap.
- Sits between the MAC TX FIFO and the board-level GMII PHY pins (txd/tx_en/tx_er). It is the counterpart of the existing GMII receive path.

Parameters:
- ENABLE_PADDING, 1, pad payload with 0x00 up to MIN_FRAME_LENGTH-4 bytes before the FCS.
- MIN_FRAME_LENGTH, 64, minimum frame length in bytes including FCS, excluding preamble/SFD.
- IFG_CYCLES, 12, idle cycles (tx_en=0) forced after every frame; minimum value 1.

Ports:
- clk  input  1  GMII TX clock (125 MHz); all logic in this domain
- rst_n  input  1  asynchronous active-low reset
- s_axis_tdata  input  8  frame payload byte (destination MAC first)
- s_axis_tvalid  input  1  payload byte valid
- s_axis_tready  output  1  block accepts byte this cycle
- s_axis_tlast  input  1  last payload byte of frame
- s_axis_tuser  input  1  with tlast: abort/corrupt frame
- gmii_txd  output  8  GMII transmit data
- gmii_tx_en  output  1  GMII transmit enable
- gmii_tx_er  output  1  GMII transmit error
- start_packet  output  1  one-cycle pulse on the first preamble byte
- error_underflow  output  1  one-cycle pulse when tvalid drops mid-frame

Behaviour:
- Reset (async assert, sync release): state=IDLE; gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0, s_axis_tready=0, start_packet=0, error_underflow=0, CRC=0xFFFFFFFF.
- All GMII outputs are registered. A byte accepted on the AXIS in cycle N appears on gmii_txd in cycle N+1.
- FSM states: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DRAIN, IFG.
- IDLE: tready=0. When tvalid=1, go to PREAMBLE. The next cycle drives 0x55 with tx_en=1, and start_packet pulses.
- PREAMBLE: drives 7 bytes of 0x55, then 0xD5 (SFD), for 8 cycles total. tready=1 during the cycle that drives the SFD, so the first payload byte follows the SFD with no gap.
- PAYLOAD: tready=1. Each accepted byte is driven and folded into the CRC.
  - Byte counter: 16 bits, saturating.
  - tlast without tuser: if ENABLE_PADDING and count < MIN_FRAME_LENGTH-4, go to PAD; otherwise go to FCS.
  - tlast with tuser=1: drive that byte with tx_er=1, skip pad/FCS, go to IFG.
  - tvalid=0 in PAYLOAD (underflow): drive tx_en=1, tx_er=1, txd=0x00 for one cycle and pulse error_underflow. Go to DRAIN if tlast has not yet been seen, otherwise go to IFG.
- PAD: tready=0. Drive 0x00 (included in the CRC) until count = MIN_FRAME_LENGTH-4.
- FCS: tready=0. Drive ~CRC as 4 bytes, least-significant byte first, then go to IFG.
  - CRC: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, covers DA through pad.
- DRAIN: tx_en=0, tready=1. Discard bytes up to and including tlast, then go to IFG.
- IFG: tx_en=0, tx_er=0, txd=0x00, tready=0 for IFG_CYCLES cycles, then go to IDLE. tvalid during IFG is held off, not lost.
- Reset mid-frame: outputs return to reset values immediately. Half-sent frame is not completed.
- Simultaneous tvalid=1 on the last IFG cycle: move to IDLE; preamble starts on the following cycle (no fast path).

Decomposition:
- Shared package eth_pkg: ETH_PREAMBLE_BYTE=8'h55, ETH_SFD=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3, state enum typedef.
- Sub-module eth_crc32_byte: combinational, crc_in[31:0] + data[7:0] -> crc_out[31:0]. Reused by the receive path.

Test Plan:
- Minimum frame: ENABLE_PADDING=1, 1-byte payload 0xAA.
  - Expect 55×7, D5, AA, 59×00, then 4 FCS bytes: 72 tx_en cycles.
  - Receiver CRC over DA..FCS must equal residue 0xDEBB20E3.
  - Then 12 idle cycles.
- CRC check value: ENABLE_PADDING=0, payload ASCII "123456789".
  - FCS bytes on txd must be 0x26, 0x39, 0xF4, 0xCB in that order.
- Back-to-back: two 100-byte frames with tvalid held high.
  - Exactly 12 tx_en=0 cycles between frames; start_packet pulses twice.
- Underflow: drop tvalid for 1 cycle at payload byte 20 of 64.
  - One cycle with tx_en=1, tx_er=1; error_underflow pulses; remaining bytes consumed with tx_en=0; then IFG.
- Abort: tlast with tuser=1 on byte 70.
  - That byte is driven with tx_er=1; no FCS bytes follow; tx_en drops next cycle.
- Reset: assert rst_n=0 mid-payload.
  - All outputs 0 in the same cycle; after release, next frame starts with a clean preamble and a correct FCS.
